// File: rtl/addr_filter_core.sv
// Address-window filter: a one-deep decision stage feeds a small output FIFO.
// Passing beats are forwarded in order; dropped beats are counted and flagged.
module addr_filter_core #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  pclock,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [1:0]            ctrl_reg,
  input  logic                  config_b,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  drop_hit
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;

  logic                    stage_valid_reg;
  logic                    stage_pass_reg;
  logic [ADDR_WIDTH-1:0]   stage_addr_reg;
  logic [DATA_WIDTH-1:0]   stage_data_reg;

  logic [ADDR_WIDTH-1:0]   mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [PTR_W:0]          fifo_count_reg;
  logic [PTR_W:0]          occupancy;

  logic [CNT_WIDTH-1:0]    pass_cnt_reg;
  logic [CNT_WIDTH-1:0]    drop_cnt_reg;
  logic                    drop_hit_reg;

  logic                    accept;
  logic                    hit;
  logic                    pass_bit;
  logic                    push;
  logic                    pop;
  logic                    drop;

  // An inverted window (start > end) can never satisfy both bounds, so hit stays 0.
  assign hit       = (in_addr >= start_addr) && (in_addr <= end_addr);
  assign pass_bit  = !ctrl_reg[0] ? 1'b1 : (hit ^ ctrl_reg[1]);
  assign accept    = in_valid && in_ready;
  assign push      = stage_valid_reg && stage_pass_reg;
  assign drop      = stage_valid_reg && !stage_pass_reg;
  assign out_valid = (fifo_count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign occupancy = fifo_count_reg + (PTR_W+1)'(stage_valid_reg);

  always_ff @(posedge pclock) begin
    if (preset) begin
      state_reg <= WAIT_CFG;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_CFG: if (config_b) state_next = RUN;
      RUN:      if (!config_b) state_next = DRAIN;
      DRAIN:    if (!stage_valid_reg && (fifo_count_reg == '0)) state_next = WAIT_CFG;
      default:  state_next = WAIT_CFG;
    endcase
  end

  // Counting the stage beat as occupied guarantees room for it in the FIFO next edge.
  always_comb begin
    in_ready = 1'b0;
    if ((state_reg == RUN) && (occupancy < DEPTH_C)) in_ready = 1'b1;
  end

  always_ff @(posedge pclock) begin
    if (preset) begin
      stage_valid_reg <= 1'b0;
      stage_pass_reg  <= 1'b0;
      stage_addr_reg  <= '0;
      stage_data_reg  <= '0;
    end else begin
      stage_valid_reg <= accept;
      if (accept) begin
        stage_pass_reg <= pass_bit;
        stage_addr_reg <= in_addr;
        stage_data_reg <= in_data;
      end
    end
  end

  always_ff @(posedge pclock) begin
    if (push) begin
      mem_addr[wr_ptr_reg] <= stage_addr_reg;
      mem_data[wr_ptr_reg] <= stage_data_reg;
    end
  end

  always_ff @(posedge pclock) begin
    if (preset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + (PTR_W+1)'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - (PTR_W+1)'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  assign out_addr = out_valid ? mem_addr[rd_ptr_reg] : '0;
  assign out_data = out_valid ? mem_data[rd_ptr_reg] : '0;

  always_ff @(posedge pclock) begin
    if (preset) begin
      pass_cnt_reg <= '0;
      drop_cnt_reg <= '0;
      drop_hit_reg <= 1'b0;
    end else begin
      drop_hit_reg <= drop;
      if (clr_cnt) begin
        pass_cnt_reg <= '0;
        drop_cnt_reg <= '0;
      end else begin
        if (push && (pass_cnt_reg != '1)) pass_cnt_reg <= pass_cnt_reg + CNT_WIDTH'(1);
        if (drop && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign pass_cnt = pass_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
  assign drop_hit = drop_hit_reg;

endmodule
